// File: rtl/simple_rd_rsp.sv
// simple_rd_rsp: read responder for the simple address/read-data bus.
// One request at a time: the addressed bank word is captured at accept,
// WAIT_CYC wait states follow, then the word is offered with valid/ready.
// A side write port updates the bank in any state (read-before-write on
// a same-cycle collision).
// Optional build macro SIMPLE_RD_RSP_RD_CNT_EN adds o_rd_cnt, a 16-bit
// wrapping count of completed response handshakes.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for a request (o_req_rdy high once out of reset)
// ST_WAIT | counting wait states down to the response
// ST_RESP | o_rsp_vld high, data held until i_rsp_rdy
module simple_rd_rsp #(
  parameter int ADDR_BIT_WIDTH = 2,
  parameter int DATA_BIT_WIDTH = 8,
  parameter int WAIT_CYC       = 2
) (
  input  logic                      i_clk,
  input  logic                      i_arst_n,
  input  logic                      i_req_vld,
  output logic                      o_req_rdy,
  input  logic [ADDR_BIT_WIDTH-1:0] i_req_addr,
  output logic                      o_rsp_vld,
  input  logic                      i_rsp_rdy,
  output logic [DATA_BIT_WIDTH-1:0] o_rsp_data,
  input  logic                      i_wr_en,
  input  logic [ADDR_BIT_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_BIT_WIDTH-1:0] i_wr_data,
`ifdef SIMPLE_RD_RSP_RD_CNT_EN
  output logic [15:0]               o_rd_cnt,
`endif
  output logic                      o_busy
);

  localparam int DEPTH = 1 << ADDR_BIT_WIDTH;
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC);

  if (ADDR_BIT_WIDTH < 1 || ADDR_BIT_WIDTH > 8) begin : g_bad_addr_width
    $error("simple_rd_rsp: ADDR_BIT_WIDTH must be in 1..8");
  end
  if (DATA_BIT_WIDTH < 1 || DATA_BIT_WIDTH > 64) begin : g_bad_data_width
    $error("simple_rd_rsp: DATA_BIT_WIDTH must be in 1..64");
  end
  if (WAIT_CYC < 0 || WAIT_CYC > 15) begin : g_bad_wait_cyc
    $error("simple_rd_rsp: WAIT_CYC must be in 0..15");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [DATA_BIT_WIDTH-1:0] data_q, data_d;
  logic                      rdy_q, rdy_d;
  logic [DATA_BIT_WIDTH-1:0] bank_q [DEPTH];
  logic [DATA_BIT_WIDTH-1:0] bank_d [DEPTH];
  logic                      req_hs;
  logic                      rsp_hs;

  // rdy_q is only ever set while sitting in IDLE, so it alone gates accept
  assign req_hs = i_req_vld && rdy_q;
  assign rsp_hs = (state_q == ST_RESP) && i_rsp_rdy;

  // State register
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (req_hs) state_d = (WAIT_CYC > 0) ? ST_WAIT : ST_RESP;
      ST_WAIT: if (cnt_q == 4'd1) state_d = ST_RESP;
      ST_RESP: if (i_rsp_rdy) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state and the datapath registers
  always_comb begin
    o_req_rdy  = rdy_q;
    o_rsp_vld  = (state_q == ST_RESP);
    o_busy     = (state_q != ST_IDLE);
    o_rsp_data = data_q;
  end

  // Capture, wait counter and registered ready. Ready is registered from
  // "idle and not accepting", so it lags IDLE by one cycle: low during
  // reset, and low for the first IDLE cycle after a response handshake.
  always_comb begin
    cnt_d  = cnt_q;
    data_d = data_q;
    rdy_d  = (state_q == ST_IDLE) && !req_hs;
    if (req_hs) begin
      cnt_d  = CNT_LOAD;
      data_d = bank_q[i_req_addr];
    end else if (state_q == ST_WAIT) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // Datapath registers
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      cnt_q  <= '0;
      data_q <= '0;
      rdy_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
      rdy_q  <= rdy_d;
    end
  end

  // Bank write port, independent of the FSM
  always_comb begin
    bank_d = bank_q;
    if (i_wr_en) bank_d[i_wr_addr] = i_wr_data;
  end

  // Bank registers; cleared by reset
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      bank_q <= '{default: '0};
    end else begin
      bank_q <= bank_d;
    end
  end

`ifdef SIMPLE_RD_RSP_RD_CNT_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;

  // Completed-read counter, wraps naturally at 16 bits
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    if (rsp_hs) rd_cnt_d = rd_cnt_q + 16'd1;
  end

  // Read counter register
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      rd_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign o_rd_cnt = rd_cnt_q;
`else
  logic unused_rsp_hs;
  assign unused_rsp_hs = rsp_hs;
`endif

endmodule

// File: tb/tb_simple_rd_rsp.sv
// Bench for simple_rd_rsp: main instance with WAIT_CYC=2 checked every
// cycle against a timestamp-based transaction model, plus a WAIT_CYC=0
// instance for the back-to-back sequence.
module tb_simple_rd_rsp;

  localparam int W = 2;

  logic       clk;
  logic       arst_n;
  logic       req_vld, req_rdy, rsp_vld, rsp_rdy, wr_en, busy;
  logic [1:0] req_addr, wr_addr;
  logic [7:0] rsp_data, wr_data;
  logic       req_vld_z, req_rdy_z, rsp_vld_z, rsp_rdy_z, wr_en_z, busy_z;
  logic [1:0] req_addr_z, wr_addr_z;
  logic [7:0] rsp_data_z, wr_data_z;
`ifdef SIMPLE_RD_RSP_RD_CNT_EN
  logic [15:0] rd_cnt, rd_cnt_z;
`endif

  simple_rd_rsp #(.ADDR_BIT_WIDTH(2), .DATA_BIT_WIDTH(8), .WAIT_CYC(W)) dut (
    .i_clk(clk), .i_arst_n(arst_n),
    .i_req_vld(req_vld), .o_req_rdy(req_rdy), .i_req_addr(req_addr),
    .o_rsp_vld(rsp_vld), .i_rsp_rdy(rsp_rdy), .o_rsp_data(rsp_data),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
`ifdef SIMPLE_RD_RSP_RD_CNT_EN
    .o_rd_cnt(rd_cnt),
`endif
    .o_busy(busy)
  );

  simple_rd_rsp #(.ADDR_BIT_WIDTH(2), .DATA_BIT_WIDTH(8), .WAIT_CYC(0)) dut_z (
    .i_clk(clk), .i_arst_n(arst_n),
    .i_req_vld(req_vld_z), .o_req_rdy(req_rdy_z), .i_req_addr(req_addr_z),
    .o_rsp_vld(rsp_vld_z), .i_rsp_rdy(rsp_rdy_z), .o_rsp_data(rsp_data_z),
    .i_wr_en(wr_en_z), .i_wr_addr(wr_addr_z), .i_wr_data(wr_data_z),
`ifdef SIMPLE_RD_RSP_RD_CNT_EN
    .o_rd_cnt(rd_cnt_z),
`endif
    .o_busy(busy_z)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a read is either in flight (accepted at acc_cyc) or not.
  // Response valid from acc_cyc+1+W; ready returns two cycles after handshake.
  int          cyc;
  bit          inflight;
  int          acc_cyc;
  int          rdy_from;
  logic [7:0]  cap;
  logic [7:0]  bank_m [4];
  logic [15:0] n_rd;

  function automatic bit m_rdy();
    return !inflight && (cyc >= rdy_from);
  endfunction

  function automatic bit m_vld();
    return inflight && (cyc >= acc_cyc + 1 + W);
  endfunction

  task automatic model_reset();
    cyc = 0; inflight = 0; acc_cyc = 0; rdy_from = 1; cap = 8'h00; n_rd = 16'h0;
    for (int i = 0; i < 4; i++) bank_m[i] = 8'h00;
  endtask

  // Called at a negedge: check cycle outputs, drive inputs, advance the model.
  task automatic step(input bit rv, input logic [1:0] ra, input bit rr,
                      input bit we, input logic [1:0] wa, input logic [7:0] wd);
    bit erdy, evld;
    erdy = m_rdy();
    evld = m_vld();
    chk("req_rdy", 32'(req_rdy), 32'(erdy));
    chk("rsp_vld", 32'(rsp_vld), 32'(evld));
    chk("busy", 32'(busy), 32'(inflight));
    chk("rsp_data", 32'(rsp_data), 32'(cap));
`ifdef SIMPLE_RD_RSP_RD_CNT_EN
    chk("rd_cnt", 32'(rd_cnt), 32'(n_rd));
`endif
    req_vld = rv; req_addr = ra; rsp_rdy = rr;
    wr_en = we; wr_addr = wa; wr_data = wd;
    if (erdy && rv) begin
      inflight = 1; acc_cyc = cyc; cap = bank_m[ra];
    end else if (evld && rr) begin
      inflight = 0; rdy_from = cyc + 2; n_rd = n_rd + 16'd1;
    end
    if (we) bank_m[wa] = wd;
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 2'd0, 0, 0, 2'd0, 8'h00);
  endtask

  task automatic apply_reset();
    arst_n = 1'b0;
    req_vld = 0; rsp_rdy = 0; wr_en = 0; req_addr = 0; wr_addr = 0; wr_data = 0;
    req_vld_z = 0; rsp_rdy_z = 0; wr_en_z = 0; req_addr_z = 0; wr_addr_z = 0; wr_data_z = 0;
    #1;
    chk("rst_req_rdy", 32'(req_rdy), 32'd0);
    chk("rst_rsp_vld", 32'(rsp_vld), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    model_reset();
  endtask

  // Full read: optional write in the accept cycle, fixed latency check,
  // data check, and ready returning two cycles after the handshake.
  task automatic do_read(input logic [1:0] a, input bit we, input logic [1:0] wa,
                         input logic [7:0] wd, input logic [7:0] exp, input string nm);
    int k;
    int n;
    k = 0;
    while (!m_rdy() && k < 20) begin idle(1); k++; end
    if (k == 20) chk({nm, "_accept_timeout"}, 32'(k), 32'd0);
    step(1, a, 1, we, wa, wd);
    n = 1;
    while (rsp_vld !== 1'b1 && n < 20) begin step(0, a, 1, 0, 2'd0, 8'h00); n++; end
    chk({nm, "_latency"}, 32'(n), 32'(1 + W));
    chk({nm, "_data"}, 32'(rsp_data), 32'(exp));
    step(0, a, 1, 0, 2'd0, 8'h00);
    chk({nm, "_rdy_hs1"}, 32'(req_rdy), 32'd0);
    idle(1);
    chk({nm, "_rdy_hs2"}, 32'(req_rdy), 32'd1);
  endtask

  typedef struct {
    bit         we;
    logic [1:0] wa;
    logic [7:0] wd;
    logic [1:0] ra;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int n_acc, n_rsp, low_run, t_acc, c;
    logic [1:0] idx;

    tbl[0] = '{we: 1'b0, wa: 2'd0, wd: 8'h00, ra: 2'd1, exp: 8'hA5};
    tbl[1] = '{we: 1'b1, wa: 2'd2, wd: 8'h33, ra: 2'd1, exp: 8'hA5};
    tbl[2] = '{we: 1'b1, wa: 2'd2, wd: 8'h7E, ra: 2'd2, exp: 8'h33};
    tbl[3] = '{we: 1'b0, wa: 2'd0, wd: 8'h00, ra: 2'd2, exp: 8'h7E};
    tbl[4] = '{we: 1'b1, wa: 2'd0, wd: 8'h5C, ra: 2'd3, exp: 8'h00};
    tbl[5] = '{we: 1'b0, wa: 2'd0, wd: 8'h00, ra: 2'd0, exp: 8'h5C};

    apply_reset();
    idle(1);

    // WAIT_CYC=0 instance: preload 0x11..0x44 then hold a request for 0..3
    for (int i = 0; i < 4; i++) begin
      wr_en_z = 1; wr_addr_z = 2'(i); wr_data_z = 8'(8'h11 * (i + 1));
      idle(1);
    end
    wr_en_z = 0;
    rsp_rdy_z = 1;
    n_acc = 0; n_rsp = 0; low_run = 0; t_acc = 0;
    for (c = 0; c < 16; c++) begin
      if (rsp_vld_z) begin
        chk("b2b_rsp_latency", 32'(c - t_acc), 32'd1);
        chk("b2b_rsp_data", 32'(rsp_data_z), 32'(8'h11 * (n_rsp + 1)));
        n_rsp++;
      end
      if (!req_rdy_z) low_run++;
      else begin
        if (low_run > 0) chk("b2b_rdy_low_cycles", 32'(low_run), 32'd2);
        low_run = 0;
      end
      idx = 2'(n_acc);
      req_addr_z = idx;
      req_vld_z = (n_acc < 4);
      if (req_rdy_z && req_vld_z) begin
        t_acc = c; n_acc++;
      end
      idle(1);
    end
    req_vld_z = 0;
    chk("b2b_accepts", 32'(n_acc), 32'd4);
    chk("b2b_responses", 32'(n_rsp), 32'd4);

    // Directed reads on the WAIT_CYC=2 instance
    step(0, 2'd0, 0, 1, 2'd1, 8'hA5);
    for (int i = 0; i < 6; i++)
      do_read(tbl[i].ra, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].exp, $sformatf("tbl%0d", i));

    // Back-pressure in RESP while toggling request and rewriting the address
    begin
      int k;
      while (!m_rdy()) idle(1);
      step(1, 2'd0, 0, 0, 2'd0, 8'h00);
      k = 0;
      while (rsp_vld !== 1'b1 && k < 20) begin step(0, 2'd0, 0, 0, 2'd0, 8'h00); k++; end
      for (int i = 0; i < 5; i++) begin
        chk("bp_vld", 32'(rsp_vld), 32'd1);
        chk("bp_data", 32'(rsp_data), 32'h5C);
        chk("bp_no_accept", 32'(req_rdy), 32'd0);
        step(bit'(i % 2 == 0), 2'd0, 0, 1, 2'd0, 8'(8'hC0 + i));
      end
      step(0, 2'd0, 1, 0, 2'd0, 8'h00);
      chk("bp_vld_drop", 32'(rsp_vld), 32'd0);
      chk("bp_data_hold", 32'(rsp_data), 32'h5C);
      do_read(2'd0, 0, 2'd0, 8'h00, 8'hC4, "bp_after");
    end

    // Randomized traffic checked against the model every cycle
    for (int i = 0; i < 400; i++)
      step(bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), bit'($urandom_range(0, 3) != 0),
           bit'($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    idle(4);

    // Asynchronous reset in the middle of WAIT
    while (!m_rdy()) idle(1);
    step(1, 2'd1, 1, 0, 2'd0, 8'h00);
    step(0, 2'd1, 1, 0, 2'd0, 8'h00);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    apply_reset();
    idle(1);
    for (int i = 0; i < 4; i++) begin
      do_read(2'(i), 0, 2'd0, 8'h00, 8'h00, "post_rst");
`ifdef SIMPLE_RD_RSP_RD_CNT_EN
      if (i == 2) chk("rd_cnt_three", 32'(rd_cnt), 32'd3);
`endif
    end

`ifdef SIMPLE_RD_RSP_RD_CNT_EN
    force dut.rd_cnt_q = 16'hFFFF;
    #1;
    release dut.rd_cnt_q;
    n_rd = 16'hFFFF;
    do_read(2'd1, 0, 2'd0, 8'h00, 8'h00, "cnt_wrap");
    chk("rd_cnt_wrap", 32'(rd_cnt), 32'd0);
    #2;
    apply_reset();
    chk("rd_cnt_reset", 32'(rd_cnt), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
